regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised integer register file for the tiny_riscv core. It provides NRD combinational read ports with write-back bypass and one write-back port from ex. A per-register busy scoreboard drives hazard detection in id. A debug (jtag) access port with a req/gnt handshake and an anti-starvation stall request completes the block. It replaces the fixed two-read-port register file between id, ex and the jtag debug module.

## Interface
Parameters:
- XLEN, 32, register width
- NREG, 32, register count; power of two; AW = clog2(NREG)
- NRD, 2, number of read ports (1..4)
- DBG_WAIT_MAX, 8, consecutive blocked debug cycles before stall_req_o asserts (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- we_i  in  1  write-back enable from ex
- waddr_i  in  AW  write-back address
- wdata_i  in  XLEN  write-back data
- issue_i  in  1  id issues an instruction writing issue_addr_i (mark busy)
- issue_addr_i  in  AW  destination of issued instruction
- raddr_i  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- rdata_o  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- rbusy_o  out  NRD  read operand k still pending
- dbg_req_i  in  1  debug access request, held until dbg_gnt_o
- dbg_we_i  in  1  1 = write, 0 = read; stable while dbg_req_i
- dbg_addr_i  in  AW  debug address
- dbg_wdata_i  in  XLEN  debug write data
- dbg_gnt_o  out  1  one-cycle access-complete pulse
- dbg_rdata_o  out  XLEN  debug read data, valid with dbg_gnt_o
- stall_req_o  out  1  request to pipeline to hold write-back

## Operation
- Register 0: reads return 0, writes from either source are dropped, never busy.
- Array contents are not reset.
- Read port k is combinational:
  - address 0 -> 0
  - else we_i && waddr_i==raddr -> wdata_i (bypass)
  - else array value
- Scoreboard busy[NREG]:
  - Set on issue_i at the clock edge.
  - Cleared on we_i to the same address.
  - Simultaneous issue_i and we_i to the same address -> stays set (issue wins).
  - Issue to address 0 is ignored.
- rbusy_o[k] = busy[raddr_k] && !(we_i && waddr_i==raddr_k); 0 for address 0.
- Write-back always has priority over debug. Debug accesses execute only in cycles with we_i=0.
- Debug FSM states IDLE, WAIT, DONE:
  - IDLE: on dbg_req_i with we_i=0, perform the access at this edge -> DONE. On dbg_req_i with we_i=1 -> WAIT with wcnt=1.
  - WAIT: on we_i=0, perform the access -> DONE. Otherwise wcnt increments, saturating at DBG_WAIT_MAX.
  - DONE: dbg_gnt_o=1 for this single cycle, then -> IDLE unconditionally. dbg_req_i is ignored in DONE.
- Access: a read latches array[dbg_addr_i] (0 for address 0) into dbg_rdata_o. A write updates the array (unless address 0) and sets dbg_rdata_o=0.
- Debug writes do not change busy bits.
- stall_req_o = (state==WAIT) && (wcnt==DBG_WAIT_MAX), registered. It deasserts on entry to DONE.
- rst: state IDLE, wcnt 0, all busy cleared, dbg_gnt_o 0, dbg_rdata_o 0, stall_req_o 0. A debug access in flight is abandoned with no gnt; the master re-requests.

## Timing
- Read ports and rbusy_o have zero latency. Write-back is visible in the array one edge after we_i, and visible through bypass in the same cycle.
- Unblocked debug: dbg_req_i sampled high in cycle N -> dbg_gnt_o high in cycle N+1. Minimum request spacing is 2 cycles.
- Blocked debug: stall_req_o rises in the cycle after DBG_WAIT_MAX consecutive blocked cycles. dbg_gnt_o arrives in the cycle after the first edge sampled with we_i=0.
- Debug read and write-back to the same address never coincide, since debug never executes while we_i=1.

## Test plan
- we_i=1, waddr=5, wdata=0xDEADBEEF, raddr0=5 in the same cycle -> rdata0=0xDEADBEEF. The next cycle with we_i=0 still reads 0xDEADBEEF.
- Write 0x1234 to x0 via write-back and via debug -> all read ports and a debug read return 0.
- issue_i on x7 -> rbusy=1 for raddr=7 next cycle. we_i to x7 -> rbusy=0 combinationally that cycle. issue_i and we_i on x7 in the same cycle -> busy stays 1.
- Debug read of x3=0x55 with we_i=0 -> dbg_gnt_o and dbg_rdata_o=0x55 exactly one cycle later, for one cycle.
- DBG_WAIT_MAX=8, we_i held 1 with dbg_req_i=1 -> stall_req_o rises after 8 blocked cycles. Dropping we_i -> gnt next cycle and stall_req_o falls.
- rst asserted while in WAIT with busy bits set -> no gnt, stall_req_o=0, all rbusy_o=0. The FSM accepts a new request in the cycle after rst deasserts.

Source files
------------

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: signal bundle of regfile_mp.
// Carries write-back, issue, the read ports and the debug access port.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);

    logic                 we_i;
    logic [AW-1:0]        waddr_i;
    logic [XLEN-1:0]      wdata_i;
    logic                 issue_i;
    logic [AW-1:0]        issue_addr_i;
    logic [NRD*AW-1:0]    raddr_i;
    logic [NRD*XLEN-1:0]  rdata_o;
    logic [NRD-1:0]       rbusy_o;
    logic                 dbg_req_i;
    logic                 dbg_we_i;
    logic [AW-1:0]        dbg_addr_i;
    logic [XLEN-1:0]      dbg_wdata_i;
    logic                 dbg_gnt_o;
    logic [XLEN-1:0]      dbg_rdata_o;
    logic                 stall_req_o;

    modport master (
        output we_i, waddr_i, wdata_i, issue_i, issue_addr_i, raddr_i,
               dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  rdata_o, rbusy_o, dbg_gnt_o, dbg_rdata_o, stall_req_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, issue_i, issue_addr_i, raddr_i,
               dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output rdata_o, rbusy_o, dbg_gnt_o, dbg_rdata_o, stall_req_o
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: tiny_riscv integer register file with NRD bypassed read ports,
// a busy scoreboard for hazard detection and a debug port that yields to write-back.
module regfile_mp #(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int NRD          = 2,
    parameter int DBG_WAIT_MAX = 8
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(DBG_WAIT_MAX + 1);
    localparam logic [CW-1:0] WCNT_MAX = CW'(DBG_WAIT_MAX);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} dbg_state_t;

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    dbg_state_t      state;
    logic [CW-1:0]   wcnt;
    logic [CW-1:0]   wcnt_inc;
    logic            dbg_exec;
    logic [XLEN-1:0] dbg_rd_val;
    logic [XLEN-1:0] dbg_result;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          wb_hit;
        assign ra     = bus.raddr_i[k*AW +: AW];
        assign wb_hit = bus.we_i && (bus.waddr_i == ra);
        assign bus.rdata_o[k*XLEN +: XLEN] = (ra == '0) ? '0 :
                                             wb_hit     ? bus.wdata_i : mem[ra];
        assign bus.rbusy_o[k] = (ra != '0) && busy[ra] && !wb_hit;
    end

    // Debug only touches the array in cycles where write-back is idle.
    assign dbg_exec   = !rst && !bus.we_i &&
                        ((state == IDLE && bus.dbg_req_i) || state == WAIT);
    assign dbg_rd_val = (bus.dbg_addr_i == '0) ? '0 : mem[bus.dbg_addr_i];
    assign dbg_result = bus.dbg_we_i ? '0 : dbg_rd_val;
    assign wcnt_inc   = (wcnt == WCNT_MAX) ? wcnt : wcnt + CW'(1);

    always_ff @(posedge clk) begin
        if (bus.we_i) begin
            if (bus.waddr_i != '0) mem[bus.waddr_i] <= bus.wdata_i;
        end else if (dbg_exec && bus.dbg_we_i && bus.dbg_addr_i != '0) begin
            mem[bus.dbg_addr_i] <= bus.dbg_wdata_i;
        end
    end

    // Issue is applied after the write-back clear so a same-address pair stays busy.
    always_comb begin
        busy_nxt = busy;
        if (bus.we_i) busy_nxt[bus.waddr_i] = 1'b0;
        if (bus.issue_i && bus.issue_addr_i != '0) busy_nxt[bus.issue_addr_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wcnt            <= '0;
            bus.dbg_gnt_o   <= 1'b0;
            bus.dbg_rdata_o <= '0;
            bus.stall_req_o <= 1'b0;
        end else begin
            bus.dbg_gnt_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.dbg_req_i) begin
                        if (!bus.we_i) begin
                            state           <= DONE;
                            bus.dbg_gnt_o   <= 1'b1;
                            bus.dbg_rdata_o <= dbg_result;
                        end else begin
                            state           <= WAIT;
                            wcnt            <= CW'(1);
                            bus.stall_req_o <= (WCNT_MAX == CW'(1));
                        end
                    end
                end
                WAIT: begin
                    if (!bus.we_i) begin
                        state           <= DONE;
                        bus.dbg_gnt_o   <= 1'b1;
                        bus.dbg_rdata_o <= dbg_result;
                        bus.stall_req_o <= 1'b0;
                    end else begin
                        wcnt            <= wcnt_inc;
                        bus.stall_req_o <= (wcnt_inc == WCNT_MAX);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    wcnt  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp covering bypass, x0,
// busy scoreboard, debug access, write-back blocking/stall and reset.
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int WMAX = 8;
    localparam int AW   = 5;

    typedef struct {
        string           tag;
        int              port;
        logic [XLEN-1:0] val;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    logic stall_at_gnt;

    rd_exp_t         rd_q[$];
    logic [XLEN-1:0] dbg_q[$];

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .DBG_WAIT_MAX(WMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string tag, input int port, input logic [AW-1:0] addr,
                             input logic [XLEN-1:0] val);
        rd_exp_t e;
        bus.raddr_i[port*AW +: AW] = addr;
        e.tag  = tag;
        e.port = port;
        e.val  = val;
        rd_q.push_back(e);
    endtask

    task automatic check_rd();
        rd_exp_t e;
        #1;
        while (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk(e.tag, bus.rdata_o[e.port*XLEN +: XLEN], e.val);
        end
    endtask

    task automatic dbg_go(input logic we, input logic [AW-1:0] addr,
                          input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] exp_rdata);
        bus.dbg_req_i   = 1'b1;
        bus.dbg_we_i    = we;
        bus.dbg_addr_i  = addr;
        bus.dbg_wdata_i = wdata;
        dbg_q.push_back(exp_rdata);
    endtask

    // Waits a bounded number of cycles for gnt, then checks data, latency and pulse width.
    task automatic dbg_wait(input string tag, input int budget, input int exp_lat);
        int              n;
        logic [XLEN-1:0] exp;
        n = 0;
        while (n < budget && !bus.dbg_gnt_o) begin
            tick();
            n++;
        end
        exp = dbg_q.pop_front();
        if (!bus.dbg_gnt_o) begin
            chk({tag, "_gnt_timeout"}, 0, 1);
            bus.dbg_req_i = 1'b0;
            return;
        end
        stall_at_gnt = bus.stall_req_o;
        chk({tag, "_rdata"}, bus.dbg_rdata_o, exp);
        chk({tag, "_lat"}, n, exp_lat);
        bus.dbg_req_i = 1'b0;
        tick();
        chk({tag, "_gnt_pulse"}, bus.dbg_gnt_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.we_i         = 1'b0;
        bus.waddr_i      = '0;
        bus.wdata_i      = '0;
        bus.issue_i      = 1'b0;
        bus.issue_addr_i = '0;
        bus.raddr_i      = '0;
        bus.dbg_req_i    = 1'b0;
        bus.dbg_we_i     = 1'b0;
        bus.dbg_addr_i   = '0;
        bus.dbg_wdata_i  = '0;
        tick();
        tick();
        bus.raddr_i[0*AW +: AW] = 5'd7;
        #1;
        chk("rst_gnt", bus.dbg_gnt_o, 0);
        chk("rst_dbg_rdata", bus.dbg_rdata_o, 0);
        chk("rst_stall", bus.stall_req_o, 0);
        chk("rst_rbusy", bus.rbusy_o, 0);
        rst = 1'b0;
        tick();

        // Same-cycle bypass, then the array copy.
        bus.we_i = 1'b1; bus.waddr_i = 5'd5; bus.wdata_i = 32'hDEADBEEF;
        expect_rd("bypass_x5", 0, 5'd5, 32'hDEADBEEF);
        check_rd();
        tick();
        bus.we_i = 1'b0;
        expect_rd("array_x5", 0, 5'd5, 32'hDEADBEEF);
        check_rd();

        // x0 is hardwired from both write sources.
        bus.we_i = 1'b1; bus.waddr_i = 5'd0; bus.wdata_i = 32'h1234;
        expect_rd("x0_bypass_p0", 0, 5'd0, 32'h0);
        expect_rd("x0_bypass_p1", 1, 5'd0, 32'h0);
        check_rd();
        tick();
        bus.we_i = 1'b0;
        dbg_go(1'b1, 5'd0, 32'h1234, 32'h0);
        dbg_wait("dbg_wr_x0", 4, 1);
        dbg_go(1'b0, 5'd0, 32'h0, 32'h0);
        dbg_wait("dbg_rd_x0", 4, 1);
        expect_rd("x0_p0", 0, 5'd0, 32'h0);
        expect_rd("x0_p1", 1, 5'd0, 32'h0);
        check_rd();

        // Debug read of a written register and debug write visible on a read port.
        bus.we_i = 1'b1; bus.waddr_i = 5'd3; bus.wdata_i = 32'h55;
        tick();
        bus.we_i = 1'b0;
        dbg_go(1'b0, 5'd3, 32'h0, 32'h55);
        dbg_wait("dbg_rd_x3", 4, 1);
        dbg_go(1'b1, 5'd9, 32'hA5A50001, 32'h0);
        dbg_wait("dbg_wr_x9", 4, 1);
        expect_rd("x9_after_dbg", 1, 5'd9, 32'hA5A50001);
        check_rd();
        dbg_go(1'b0, 5'd9, 32'h0, 32'hA5A50001);
        dbg_wait("dbg_rd_x9", 4, 1);

        // Busy scoreboard.
        bus.issue_i = 1'b1; bus.issue_addr_i = 5'd7;
        tick();
        bus.issue_i = 1'b0;
        bus.raddr_i[0*AW +: AW] = 5'd7;
        #1;
        chk("busy_x7_set", bus.rbusy_o[0], 1);
        bus.we_i = 1'b1; bus.waddr_i = 5'd7; bus.wdata_i = 32'h77;
        bus.issue_i = 1'b1; bus.issue_addr_i = 5'd7;
        expect_rd("bypass_x7", 0, 5'd7, 32'h77);
        check_rd();
        chk("busy_x7_wb_clear", bus.rbusy_o[0], 0);
        tick();
        bus.we_i = 1'b0; bus.issue_i = 1'b0;
        #1;
        chk("busy_x7_issue_wins", bus.rbusy_o[0], 1);
        bus.we_i = 1'b1; bus.wdata_i = 32'h78;
        tick();
        bus.we_i = 1'b0;
        #1;
        chk("busy_x7_cleared", bus.rbusy_o[0], 0);
        bus.issue_i = 1'b1; bus.issue_addr_i = 5'd0;
        tick();
        bus.issue_i = 1'b0;
        bus.raddr_i[1*AW +: AW] = 5'd0;
        #1;
        chk("busy_x0_never", bus.rbusy_o[1], 0);

        // Debug blocked by continuous write-back.
        bus.we_i = 1'b1; bus.waddr_i = 5'd12; bus.wdata_i = 32'hC0FFEE;
        dbg_go(1'b0, 5'd3, 32'h0, 32'h55);
        for (int i = 1; i <= WMAX + 2; i++) begin
            tick();
            if (i == WMAX - 1) chk("stall_early", bus.stall_req_o, 0);
            if (i >= WMAX)     chk("stall_high", bus.stall_req_o, 1);
            if (i == WMAX + 2) chk("blocked_no_gnt", bus.dbg_gnt_o, 0);
        end
        bus.we_i = 1'b0;
        dbg_wait("dbg_blocked", 4, 1);
        chk("stall_fall_at_gnt", stall_at_gnt, 0);

        // Reset abandons an in-flight blocked access and clears busy.
        bus.issue_i = 1'b1; bus.issue_addr_i = 5'd7;
        tick();
        bus.issue_addr_i = 5'd4;
        tick();
        bus.issue_i = 1'b0;
        bus.we_i = 1'b1; bus.waddr_i = 5'd12;
        bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = 5'd3;
        for (int i = 0; i < WMAX + 1; i++) tick();
        bus.raddr_i[0*AW +: AW] = 5'd7;
        bus.raddr_i[1*AW +: AW] = 5'd4;
        #1;
        chk("pre_rst_stall", bus.stall_req_o, 1);
        chk("pre_rst_rbusy", bus.rbusy_o, 2'b11);
        rst = 1'b1;
        bus.dbg_req_i = 1'b0;
        tick();
        chk("inrst_gnt", bus.dbg_gnt_o, 0);
        chk("inrst_stall", bus.stall_req_o, 0);
        chk("inrst_rbusy", bus.rbusy_o, 2'b00);
        rst = 1'b0;
        bus.we_i = 1'b0;
        dbg_go(1'b0, 5'd3, 32'h0, 32'h55);
        dbg_wait("dbg_after_rst", 4, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
